// File: rtl/camera_stream_emulator.sv
// Camera-sensor emulator: vsync/hsync/pixel-byte streams advanced by a pixel-tick enable.
// Optional macro CAMEMU_BYTE_PAIR_EN: RGB565-style two-byte pixels (high half, then low half).
module camera_stream_emulator #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned PIX_PER_LINE    = 256,
    parameter int unsigned LINES_PER_FRAME = 4,
    parameter int unsigned VSYNC_LEN       = 32,
    parameter int unsigned VS_TO_HS_DELAY  = 8,
    parameter int unsigned H_BLANK         = 8,
    parameter int unsigned SEED            = 'hAA
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pix_en,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_const,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic [DATA_W-1:0] o_data,
    output logic              o_frame_done,
    output logic              o_busy
);

    localparam int unsigned MAX_A   = (VSYNC_LEN > VS_TO_HS_DELAY) ? VSYNC_LEN : VS_TO_HS_DELAY;
    localparam int unsigned CNT_MAX = (MAX_A > H_BLANK) ? MAX_A : H_BLANK;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned XW      = $clog2(PIX_PER_LINE + 1);
    localparam int unsigned LW      = $clog2(LINES_PER_FRAME + 1);

    localparam logic [CW-1:0]     VS_LAST = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0]     VB_LAST = CW'(VS_TO_HS_DELAY - 1);
    localparam logic [CW-1:0]     HB_LAST = CW'(H_BLANK - 1);
    localparam logic [XW-1:0]     X_LAST  = XW'(PIX_PER_LINE - 1);
    localparam logic [LW-1:0]     L_LAST  = LW'(LINES_PER_FRAME - 1);
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'((1 << (DATA_W / 2)) - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [XW-1:0]     x;
    logic [LW-1:0]     line;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] const_q;
    logic              byte_lo;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] c,
        input logic [XW-1:0]     px,
        input logic [LW-1:0]     ln
    );
        case (m)
            2'd0:    pattern = DATA_W'(SEED) + DATA_W'(px);
            2'd1:    pattern = c;
            2'd2:    pattern = DATA_W'(px);
            default: pattern = ((((32'(px) ^ 32'(ln)) >> 3) & 32'd1) != 32'd0) ? '1 : '0;
        endcase
    endfunction

`ifdef CAMEMU_BYTE_PAIR_EN
    logic phase;

    // First byte of a pixel keeps only the upper half of the pattern.
    function automatic logic [DATA_W-1:0] lead_byte(input logic [DATA_W-1:0] p);
        lead_byte = p & ~LO_MASK;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase <= 1'b0;
        end else if (i_pix_en) begin
            phase <= (state == ACTIVE) ? ~phase : 1'b0;
        end
    end

    assign byte_lo = ~phase;
`else
    function automatic logic [DATA_W-1:0] lead_byte(input logic [DATA_W-1:0] p);
        lead_byte = p;
    endfunction

    assign byte_lo = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            x            <= '0;
            line         <= '0;
            mode_q       <= '0;
            const_q      <= '0;
            o_vsync      <= 1'b0;
            o_hsync      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_pix_en) begin
                case (state)
                    IDLE: begin
                        if (i_enable) begin
                            state   <= VSYNC;
                            cnt     <= '0;
                            mode_q  <= i_mode;
                            const_q <= i_const;
                            o_vsync <= 1'b1;
                            o_busy  <= 1'b1;
                        end
                    end
                    VSYNC: begin
                        if (cnt == VS_LAST) begin
                            state   <= VBACK;
                            cnt     <= '0;
                            o_vsync <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    VBACK: begin
                        if (cnt == VB_LAST) begin
                            state   <= ACTIVE;
                            cnt     <= '0;
                            x       <= '0;
                            line    <= '0;
                            o_hsync <= 1'b1;
                            o_data  <= lead_byte(pattern(mode_q, const_q, '0, '0));
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        // o_data already shows pixel x; each tick loads the next byte to show.
                        if (byte_lo) begin
                            o_data <= pattern(mode_q, const_q, x, line) & LO_MASK;
                        end else if (x == X_LAST) begin
                            state   <= HBLANK;
                            x       <= '0;
                            o_hsync <= 1'b0;
                            o_data  <= '0;
                        end else begin
                            x      <= x + 1'b1;
                            o_data <= lead_byte(pattern(mode_q, const_q, x + 1'b1, line));
                        end
                    end
                    HBLANK: begin
                        if (cnt != HB_LAST) begin
                            cnt <= cnt + 1'b1;
                        end else if (line != L_LAST) begin
                            state   <= ACTIVE;
                            cnt     <= '0;
                            x       <= '0;
                            line    <= line + 1'b1;
                            o_hsync <= 1'b1;
                            o_data  <= lead_byte(pattern(mode_q, const_q, '0, line + 1'b1));
                        end else begin
                            cnt          <= '0;
                            line         <= '0;
                            o_frame_done <= 1'b1;
                            if (i_enable) begin
                                state   <= VSYNC;
                                mode_q  <= i_mode;
                                const_q <= i_const;
                                o_vsync <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        o_vsync <= 1'b0;
                        o_hsync <= 1'b0;
                        o_data  <= '0;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_stream_emulator.sv
// Self-checking bench for camera_stream_emulator: every tick is compared against a frame-trace model.
// Honours CAMEMU_BYTE_PAIR_EN so the same bench covers both builds.
module tb_camera_stream_emulator;

    localparam int DW  = 8;
    localparam int PIX = 20;
    localparam int LPF = 12;
    localparam int VSL = 5;
    localparam int VBD = 3;
    localparam int HB  = 4;
    localparam int unsigned SD = 'hF5;
`ifdef CAMEMU_BYTE_PAIR_EN
    localparam int BPP = 2;
`else
    localparam int BPP = 1;
`endif
    localparam int LINE_T = PIX * BPP + HB;
    localparam int FLEN   = VSL + VBD + LPF * LINE_T;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_en = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] cval = '0;
    logic          vs, hs, fd, busy;
    logic [DW-1:0] data;

    int            ncmp = 0;
    int            nfail = 0;
    logic [11:0]   q[$];
    logic [11:0]   prev = '0;

    camera_stream_emulator #(
        .DATA_W(DW),
        .PIX_PER_LINE(PIX),
        .LINES_PER_FRAME(LPF),
        .VSYNC_LEN(VSL),
        .VS_TO_HS_DELAY(VBD),
        .H_BLANK(HB),
        .SEED(SD)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_pix_en(pix_en),
        .i_enable(en),
        .i_mode(mode),
        .i_const(cval),
        .o_vsync(vs),
        .o_hsync(hs),
        .o_data(data),
        .o_frame_done(fd),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Observed/expected word layout: {vsync, hsync, busy, frame_done, data[7:0]}
    function automatic logic [11:0] obs();
        return {vs, hs, busy, fd, data};
    endfunction

    function automatic logic [11:0] ent(bit v, bit h, bit b, bit f, logic [7:0] d);
        return {v, h, b, f, d};
    endfunction

    function automatic logic [7:0] pat(int m, int c, int x, int ln);
        case (m)
            0:       return 8'((SD + x) % 256);
            1:       return 8'(c);
            2:       return 8'(x % 256);
            default: return (((x / 8) % 2) != ((ln / 8) % 2)) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic chk(string tag, logic [11:0] o, logic [11:0] e);
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h at %0t", tag, o, e, $time);
        end
    endtask

    task automatic push_frame(int m, int c, bit fd0);
        logic [7:0] p;
        for (int i = 0; i < VSL; i++) q.push_back(ent(1, 0, 1, (i == 0) && fd0, 8'h00));
        for (int i = 0; i < VBD; i++) q.push_back(ent(0, 0, 1, 0, 8'h00));
        for (int ln = 0; ln < LPF; ln++) begin
            for (int x = 0; x < PIX; x++) begin
                p = pat(m, c, x, ln);
                if (BPP == 2) begin
                    q.push_back(ent(0, 1, 1, 0, p & 8'hF0));
                    q.push_back(ent(0, 1, 1, 0, p & 8'h0F));
                end else begin
                    q.push_back(ent(0, 1, 1, 0, p));
                end
            end
            for (int i = 0; i < HB; i++) q.push_back(ent(0, 0, 1, 0, 8'h00));
        end
    endtask

    task automatic push_idle(bit f);
        q.push_back(ent(0, 0, 0, f, 8'h00));
    endtask

    // per > 1 stretches each tick over per clocks; between ticks outputs must hold and frame_done must be low.
    task automatic run(int n, int per);
        logic [11:0] e;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < per; k++) begin
                pix_en = (k == per - 1);
                @(posedge clk);
                #1;
                if (k < per - 1) begin
                    chk("hold", obs(), prev & 12'hEFF);
                end else if (q.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $error("FAIL model_underflow: got %h expected nothing", obs());
                end else begin
                    e = q.pop_front();
                    chk("tick", obs(), e);
                    prev = e;
                end
            end
        end
        pix_en = 1'b0;
    endtask

    initial begin
        int          m;
        int          c;
        int          per;
        #12;
        chk("reset_state", obs(), 12'h000);
        @(negedge clk);
        rst = 1'b0;
        prev = '0;

        // Frame A: counter pattern, full rate, wraps past 0xFF inside a line.
        en = 1'b1;
        mode = 2'd0;
        push_frame(0, 0, 1'b0);
        run(FLEN, 1);

        // Frame B: constant 0x5C at 1-in-4 tick rate; mode changes mid-frame must not leak in.
        mode = 2'd1;
        cval = 8'h5C;
        push_frame(1, 'h5C, 1'b1);
        run(100, 4);
        mode = 2'd2;
        cval = 8'h11;
        run(FLEN - 100, 4);

        // Frame C: gradient; enable drops during line 1 and the frame still completes.
        push_frame(2, 0, 1'b1);
        run(VSL + VBD + LINE_T + 5, 1);
        en = 1'b0;
        run(FLEN - (VSL + VBD + LINE_T + 5), 1);
        push_idle(1'b1);
        for (int i = 0; i < 3; i++) push_idle(1'b0);
        run(4, 1);

        // Frame D: checkerboard across line 8 boundary, half rate.
        en = 1'b1;
        mode = 2'd3;
        cval = 8'($urandom);
        push_frame(3, 0, 1'b0);
        run(FLEN, 2);

        // Frame E: random mode/const/rate, interrupted by reset in line 0.
        m = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 255));
        per = int'($urandom_range(1, 3));
        mode = 2'(m);
        cval = 8'(c);
        push_frame(m, c, 1'b1);
        run(VSL + VBD + 7, per);
        chk("hsync_before_reset", {3'b000, hs, 8'h00}, 12'h100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", obs(), 12'h000);
        @(posedge clk);
        #1;
        chk("reset_hold", obs(), 12'h000);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        prev = '0;

        // Frame F: restart after reset with a full vsync pulse.
        m = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 255));
        mode = 2'(m);
        cval = 8'(c);
        push_frame(m, c, 1'b0);
        run(FLEN, 1);
        en = 1'b0;
        push_idle(1'b1);
        push_idle(1'b0);
        run(2, 1);

        ncmp++;
        assert (q.size() == 0) else begin
            nfail++;
            $error("FAIL model_drain: got %0d left expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
